// File: rtl/ts_arb_pkg.sv
// ---------------------------------------------------------------------------
// ts_arb_pkg
// Shared definitions for the timestamp-ordered packet arbiter:
//   state_t   - arbiter FSM encoding (IDLE=0, XFER=1)
//   TS_WIDTH  - width of the arrival timestamp carried in tuser
//   SKIP_W    - width of the per-input starvation counters
//   clog2()   - index width helper usable in parameter expressions
//   ts_older()- wrap-safe "a arrived before b" comparison
// ---------------------------------------------------------------------------
package ts_arb_pkg;

  localparam int TS_WIDTH = 32;
  localparam int SKIP_W   = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Timestamps wrap, so "older" means a lies in the half-range behind b:
  // the sign bit of the modular difference a - b.
  function automatic logic ts_older(input logic [TS_WIDTH-1:0] a,
                                    input logic [TS_WIDTH-1:0] b);
    logic [TS_WIDTH-1:0] diff;
    diff = a - b;
    return diff[TS_WIDTH-1];
  endfunction

endpackage

// File: rtl/ts_min_select.sv
// ---------------------------------------------------------------------------
// ts_min_select
// Purely combinational winner selection for the packet arbiter.
//   i_ts        C_NUM_IF packed 32-bit timestamps, input i at slice i
//   i_valid     candidate mask (inputs presenting a first beat)
//   i_force     starvation mask (skip counter reached its limit)
//   o_winner    selected input index
//   o_any_valid at least one candidate present
// A forced candidate always wins (lowest index first); otherwise the oldest
// timestamp wins, with ties going to the lowest index.
// ---------------------------------------------------------------------------
module ts_min_select
  import ts_arb_pkg::*;
#(
  parameter int C_NUM_IF = 5,
  parameter int C_IDX_W  = clog2(C_NUM_IF)
) (
  input  logic [C_NUM_IF*TS_WIDTH-1:0] i_ts,
  input  logic [C_NUM_IF-1:0]          i_valid,
  input  logic [C_NUM_IF-1:0]          i_force,
  output logic [C_IDX_W-1:0]           o_winner,
  output logic                         o_any_valid
);

  logic [C_NUM_IF-1:0] w_force_hit;
  logic                w_force_any;
  logic [C_IDX_W-1:0]  w_force_idx;
  logic [C_IDX_W-1:0]  w_age_idx;
  logic [TS_WIDTH-1:0] w_best_ts;
  logic [TS_WIDTH-1:0] w_cand_ts;
  logic                w_best_vld;

  assign w_force_hit = i_valid & i_force;

  // Walk downwards so the last hit recorded is the lowest index.
  // NOTE: every always_comb output gets a default before any branch;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_force_any = 1'b0;
    w_force_idx = '0;
    for (int i = C_NUM_IF - 1; i >= 0; i--) begin
      if (w_force_hit[i]) begin
        w_force_any = 1'b1;
        w_force_idx = C_IDX_W'(i);
      end
    end
  end

  // Linear reduction: a later input replaces the current best only when it
  // is strictly older, so equal timestamps keep the lower index.
  always_comb begin
    w_best_vld = 1'b0;
    w_best_ts  = '0;
    w_cand_ts  = '0;
    w_age_idx  = '0;
    for (int i = 0; i < C_NUM_IF; i++) begin
      w_cand_ts = i_ts[i*TS_WIDTH +: TS_WIDTH];
      if (i_valid[i] && (!w_best_vld || ts_older(w_cand_ts, w_best_ts))) begin
        w_best_vld = 1'b1;
        w_best_ts  = w_cand_ts;
        w_age_idx  = C_IDX_W'(i);
      end
    end
  end

  assign o_any_valid = |i_valid;
  assign o_winner    = w_force_any ? w_force_idx : w_age_idx;

endmodule

// File: rtl/ts_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// ts_pkt_arbiter
// Merges C_NUM_IF AXI-Stream inputs into one output, one whole packet at a
// time, ordered by the 32-bit arrival timestamp in tuser of each first beat.
// A per-input skip counter force-grants an input after C_MAX_SKIP losses.
//   axi_aclk / axi_areset     clock, asynchronous active-high reset
//   sw_rst                    synchronous soft reset (same effect)
//   s_axis_*_grp              packed inputs, input i at slice i
//   m_axis_*                  merged output (combinational pass-through)
//   grant_idx                 input currently holding the grant
//   busy                      high while a packet transfer is in progress
// ---------------------------------------------------------------------------
module ts_pkt_arbiter
  import ts_arb_pkg::*;
#(
  parameter  int C_DATA_WIDTH  = 256,
  parameter  int C_TUSER_WIDTH = 128,
  parameter  int C_NUM_IF      = 5,
  parameter  int C_TS_LSB      = 32,
  parameter  int C_MAX_SKIP    = 8,
  localparam int C_STRB_WIDTH  = C_DATA_WIDTH / 8,
  localparam int C_IDX_W       = clog2(C_NUM_IF)
) (
  input  logic                              axi_aclk,
  input  logic                              axi_areset,
  input  logic                              sw_rst,
  input  logic [C_NUM_IF*C_DATA_WIDTH-1:0]  s_axis_tdata_grp,
  input  logic [C_NUM_IF*C_STRB_WIDTH-1:0]  s_axis_tstrb_grp,
  input  logic [C_NUM_IF*C_TUSER_WIDTH-1:0] s_axis_tuser_grp,
  input  logic [C_NUM_IF-1:0]               s_axis_tvalid_grp,
  output logic [C_NUM_IF-1:0]               s_axis_tready_grp,
  input  logic [C_NUM_IF-1:0]               s_axis_tlast_grp,
  output logic [C_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [C_STRB_WIDTH-1:0]           m_axis_tstrb,
  output logic [C_TUSER_WIDTH-1:0]          m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [C_IDX_W-1:0]                grant_idx,
  output logic                              busy
);

  localparam logic [SKIP_W-1:0] C_SKIP_SAT = SKIP_W'(C_MAX_SKIP);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [C_IDX_W-1:0]  r_grant;
  logic [SKIP_W-1:0]   r_skip [C_NUM_IF];

  logic [C_NUM_IF*TS_WIDTH-1:0] w_ts;
  logic [C_NUM_IF-1:0]          w_force;
  logic [C_IDX_W-1:0]           w_winner;
  logic                         w_any_valid;
  logic                         w_decide;
  logic                         w_xfer;
  logic                         w_beat;

  logic [C_DATA_WIDTH-1:0]  w_sel_data;
  logic [C_STRB_WIDTH-1:0]  w_sel_strb;
  logic [C_TUSER_WIDTH-1:0] w_sel_user;
  logic                     w_sel_valid;
  logic                     w_sel_last;

  // Timestamp field of each head beat and the starvation mask.
  always_comb begin
    w_ts    = '0;
    w_force = '0;
    for (int i = 0; i < C_NUM_IF; i++) begin
      w_ts[i*TS_WIDTH +: TS_WIDTH] = s_axis_tuser_grp[i*C_TUSER_WIDTH + C_TS_LSB +: TS_WIDTH];
      w_force[i]                   = (r_skip[i] >= C_SKIP_SAT);
    end
  end

  ts_min_select #(
    .C_NUM_IF (C_NUM_IF),
    .C_IDX_W  (C_IDX_W)
  ) u_min_select (
    .i_ts        (w_ts),
    .i_valid     (s_axis_tvalid_grp),
    .i_force     (w_force),
    .o_winner    (w_winner),
    .o_any_valid (w_any_valid)
  );

  // In IDLE every valid input is presenting its first beat, so the
  // timestamps compared here are always packet-head timestamps.
  assign w_decide = (r_state == ST_IDLE) && w_any_valid;

  // Output mux from the registered grant.
  always_comb begin
    w_sel_data  = '0;
    w_sel_strb  = '0;
    w_sel_user  = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    for (int i = 0; i < C_NUM_IF; i++) begin
      if (r_grant == C_IDX_W'(i)) begin
        w_sel_data  = s_axis_tdata_grp[i*C_DATA_WIDTH +: C_DATA_WIDTH];
        w_sel_strb  = s_axis_tstrb_grp[i*C_STRB_WIDTH +: C_STRB_WIDTH];
        w_sel_user  = s_axis_tuser_grp[i*C_TUSER_WIDTH +: C_TUSER_WIDTH];
        w_sel_valid = s_axis_tvalid_grp[i];
        w_sel_last  = s_axis_tlast_grp[i];
      end
    end
  end

  // The soft reset silences the outputs in the same cycle it is applied,
  // matching what the asynchronous reset does through r_state.
  assign w_xfer        = (r_state == ST_XFER) && !sw_rst;
  assign m_axis_tvalid = w_xfer & w_sel_valid;
  assign m_axis_tdata  = w_xfer ? w_sel_data : '0;
  assign m_axis_tstrb  = w_xfer ? w_sel_strb : '0;
  assign m_axis_tuser  = w_xfer ? w_sel_user : '0;
  assign m_axis_tlast  = w_xfer & w_sel_last;
  assign w_beat        = m_axis_tvalid & m_axis_tready;

  always_comb begin
    s_axis_tready_grp = '0;
    for (int i = 0; i < C_NUM_IF; i++) begin
      if (w_xfer && (r_grant == C_IDX_W'(i))) s_axis_tready_grp[i] = m_axis_tready;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any_valid) w_state_nxt = ST_XFER;
      ST_XFER: if (w_beat && w_sel_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
    end else if (sw_rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_decide) r_grant <= w_winner;
    end
  end

  // NOTE: the skip counters are a handful of per-input registers, not a
  // storage array, so they are reset along with the rest of the state.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      for (int i = 0; i < C_NUM_IF; i++) r_skip[i] <= '0;
    end else if (sw_rst) begin
      for (int i = 0; i < C_NUM_IF; i++) r_skip[i] <= '0;
    end else if (w_decide) begin
      for (int i = 0; i < C_NUM_IF; i++) begin
        if (w_winner == C_IDX_W'(i)) begin
          r_skip[i] <= '0;
        end else if (s_axis_tvalid_grp[i] && (r_skip[i] < C_SKIP_SAT)) begin
          r_skip[i] <= r_skip[i] + SKIP_W'(1);
        end
      end
    end
  end

  assign grant_idx = r_grant;
  assign busy      = (r_state == ST_XFER);

endmodule

// File: doc/ts_pkt_arbiter.md
Name: ts_pkt_arbiter

Overview:
- Packet-granular arbiter merging C_NUM_IF AXI-Stream inputs into one output, ordered by the 32-bit arrival timestamp carried in tuser of each packet's first beat.
- A grant is held from the first beat through tlast, so packets never interleave.
- A per-input skip counter bounds starvation.
- Sits between per-port RX queues and the shared generator/monitor datapath.

Parameters:
- C_DATA_WIDTH, 256, tdata width (tstrb is C_DATA_WIDTH/8).
- C_TUSER_WIDTH, 128, tuser width.
- C_NUM_IF, 5, number of input interfaces (2..16).
- C_TS_LSB, 32, lsb of the 32-bit timestamp field in tuser.
- C_MAX_SKIP, 8, losses after which an input is force-granted (1..255).

Ports:
- axi_aclk  in  1  clock.
- axi_areset  in  1  asynchronous reset, active-high.
- sw_rst  in  1  synchronous soft reset, same effect as axi_areset.
- s_axis_tdata_grp  in  C_NUM_IF*C_DATA_WIDTH  packed inputs, port i at slice i.
- s_axis_tstrb_grp  in  C_NUM_IF*C_DATA_WIDTH/8  packed strobes.
- s_axis_tuser_grp  in  C_NUM_IF*C_TUSER_WIDTH  packed tuser.
- s_axis_tvalid_grp  in  C_NUM_IF  per-input valid.
- s_axis_tready_grp  out  C_NUM_IF  per-input ready.
- s_axis_tlast_grp  in  C_NUM_IF  per-input last.
- m_axis_tdata  out  C_DATA_WIDTH  merged data.
- m_axis_tstrb  out  C_DATA_WIDTH/8  merged strobe.
- m_axis_tuser  out  C_TUSER_WIDTH  merged tuser.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  merged last.
- grant_idx  out  clog2(C_NUM_IF)  currently granted input.
- busy  out  1  high in XFER state.

Behaviour:
- Reset (axi_areset async, or sw_rst sync):
  - state=IDLE, grant_idx=0, busy=0.
  - All skip counters = 0.
  - All s_axis_tready = 0; m_axis_tvalid = 0.
  - Other m_axis outputs are don't-care while tvalid=0; they are driven as 0 during reset.
- States: IDLE, XFER.
- IDLE:
  - Candidates are inputs with tvalid=1; each is presenting a first beat.
  - No candidates: stay in IDLE.
  - Force rule: if any candidate has skip_cnt >= C_MAX_SKIP, winner = lowest such index.
  - Otherwise winner = candidate with the oldest timestamp.
  - Comparison is wrap-safe: a older than b iff bit31 of (a - b) mod 2^32 is 1.
  - Equal timestamps: lowest index wins.
  - On a decision:
    - Register grant_idx=winner and go to XFER.
    - winner skip_cnt <= 0.
    - Every other candidate's skip_cnt increments, saturating at C_MAX_SKIP.
    - Non-candidates keep their count.
  - All s_axis_tready = 0 in IDLE; no data moves.
- XFER (combinational pass-through from input grant_idx):
  - m_axis_{tdata,tstrb,tuser,tlast,tvalid} = s_axis_*[grant_idx].
  - s_axis_tready[grant_idx] = m_axis_tready; all other readies = 0.
  - A beat transfers when m_axis_tvalid & m_axis_tready.
  - A transfer with tlast=1 returns the state to IDLE on the next edge.
  - The granted input deasserting tvalid mid-packet keeps the lock; the output tvalid follows it low.
  - Arrivals on other inputs do not preempt.
- Latency:
  - One bubble cycle per packet: a decision at edge k allows the first output beat in cycle k+1.
  - Steady-state throughput is L/(L+1) beats/cycle for L-beat packets.
- AXI rules:
  - m_axis_tvalid never depends on m_axis_tready.
  - Data is stable while tvalid & !tready, because the upstream holds it per AXIS.
- Single-beat packet (tvalid & tlast on the first beat): one XFER cycle, then IDLE.
- Reset mid-packet: immediate return to IDLE and all readies drop. The partial packet is truncated downstream, which is documented and accepted.
- Timestamps are sampled only in IDLE, from the current head beat. Non-first beats are never compared.

Decomposition:
- Package ts_arb_pkg:
  - state encoding (IDLE=0, XFER=1);
  - TS_WIDTH=32;
  - clog2 function;
  - wrap-safe older-than function.
- One sub-module, ts_min_select:
  - purely combinational;
  - inputs: C_NUM_IF timestamps, a valid mask and a force mask;
  - outputs: winner index and any_valid;
  - implemented as a linear or tree reduction with the lowest-index tie-break.
- The top holds the FSM, grant register, skip counters and output mux.

Test Plan:
- Three packets in parallel: in0 ts=0x100 (2 beats), in1 ts=0x080 (3 beats), in2 ts=0x200 (1 beat), tready=1.
  -> Output order in1, in0, in2.
  -> Zero interleaving; one idle cycle between packets; 9 total cycles from the first decision.
- Wrap case: in0 ts=0xFFFFFFF0, in1 ts=0x00000010.
  -> in0 granted first.
- Tie and backpressure: in0 and in3 both ts=0x50, with m_axis_tready toggled 1,0,1,0 mid-packet.
  -> in0 first; output data held stable during stalls; in3 tready=0 throughout.
- Starvation, C_MAX_SKIP=2: in4 has constant ts=0x1000 while in0 streams packets with ts 0x10, 0x11, 0x12, ...
  -> in4 loses twice, is granted on the third decision, and its skip_cnt returns to 0.
- Reset mid-packet: assert axi_areset in beat 2 of a 4-beat packet.
  -> Same cycle: all tready=0, m_axis_tvalid=0, busy=0.
  -> After release, a new packet on in2 is granted normally.
- sw_rst pulse while IDLE with skip counters nonzero.
  -> Counters cleared: a previously starved input no longer force-wins, so the oldest timestamp wins.
